vga_timing: RTL and testbench

Free-running VGA raster timing generator for 800x600 at 60 Hz with a 40 MHz pixel clock. It is the first stage of the video pipeline. It drives the `vga_if` bundle (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) that every drawing stage downstream consumes and re-registers. It produces only timing; it draws nothing, so rgb is held at black.

---
 rtl/vga_timing_if.sv | 12 +
 rtl/vga_timing.sv | 52 +++++
 tb/tb_vga_timing.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_if: raster timing bundle passed between video pipeline stages.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running 800x600@60 raster counters with registered, counter-aligned sync/blank flags.
module vga_timing #(
   parameter int HACTIVE = 800,
   parameter int HFP     = 40,
   parameter int HSW     = 128,
   parameter int HBP     = 88,
   parameter int VACTIVE = 600,
   parameter int VFP     = 1,
   parameter int VSW     = 4,
   parameter int VBP     = 23
) (
   input  logic clk,
   input  logic rst,
   vga_if.out   vga_out,
   output logic frame_start
);
   localparam int HTOTAL = HACTIVE + HFP + HSW + HBP;
   localparam int VTOTAL = VACTIVE + VFP + VSW + VBP;
   logic [10:0] hc, vc, hn, vn;
   logic        hsync, vsync, hblnk, vblnk;
   always_comb begin
      hn = (hc == 11'(HTOTAL - 1)) ? 11'd0 : hc + 11'd1;
      vn = (hc != 11'(HTOTAL - 1)) ? vc : (vc == 11'(VTOTAL - 1)) ? 11'd0 : vc + 11'd1;
   end
   // flags decode the next counter values so they land on the same cycle as the counts
   always_ff @(posedge clk) begin
      if (rst) begin
         hc          <= '0;
         vc          <= '0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hc          <= hn;
         vc          <= vn;
         hblnk       <= hn >= 11'(HACTIVE);
         hsync       <= (hn >= 11'(HACTIVE + HFP)) && (hn < 11'(HACTIVE + HFP + HSW));
         vblnk       <= vn >= 11'(VACTIVE);
         vsync       <= (vn >= 11'(VACTIVE + VFP)) && (vn < 11'(VACTIVE + VFP + VSW));
         frame_start <= (hn == 11'd0) && (vn == 11'd0);
      end
   end
   assign vga_out.hcount = hc;
   assign vga_out.vcount = vc;
   assign vga_out.hsync  = hsync;
   assign vga_out.vsync  = vsync;
   assign vga_out.hblnk  = hblnk;
   assign vga_out.vblnk  = vblnk;
   assign vga_out.rgb    = 12'h000;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for a default and a reduced-size vga_timing instance.
module tb_vga_timing;
   logic clk = 1'b0;
   logic rst_d = 1'b1;
   logic rst_s = 1'b1;
   logic fs_d, fs_s;
   vga_if vd();
   vga_if vs();
   vga_timing u_d (.clk(clk), .rst(rst_d), .vga_out(vd), .frame_start(fs_d));
   vga_timing #(.HACTIVE(16), .HFP(2), .HSW(3), .HBP(3), .VACTIVE(8), .VFP(1), .VSW(2), .VBP(1))
      u_s (.clk(clk), .rst(rst_s), .vga_out(vs), .frame_start(fs_s));
   always #5 clk = ~clk;
   logic [38:0] od, os;
   assign od = {vd.hcount, vd.vcount, vd.hsync, vd.vsync, vd.hblnk, vd.vblnk, vd.rgb, fs_d};
   assign os = {vs.hcount, vs.vcount, vs.hsync, vs.vsync, vs.hblnk, vs.vblnk, vs.rgb, fs_s};
   typedef struct {string tag; logic [38:0] v;} exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int dh = 0, dv = 0, sh = 0, sv = 0;
   bit dz = 1'b1, sz = 1'b1;
   bit meas = 1'b0;
   int k, d_hs, d_hb, d_h0n, d_h0a, d_h0b, d_fhb, d_fhs, s_fs1, s_fs2, s_fsn, s_vs, s_fhs, s_fvs;
   logic p_dhb, p_dhs, p_shs, p_svs;
   // independent raster model: position after the coming edge
   task automatic adv(input logic r, input int ht, input int vt, inout int h, inout int v, inout bit z);
      if (r) begin
         h = 0; v = 0; z = 1'b1;
      end else begin
         z = 1'b0;
         if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
         end else h++;
      end
   endtask
   function automatic logic [38:0] ev(input int h, input int v, input bit z, input int ha, input int hf,
                                      input int hw, input int va, input int vf, input int vw);
      if (z) return '0;
      return {11'(h), 11'(v), (h >= ha + hf) && (h < ha + hf + hw), (v >= va + vf) && (v < va + vf + vw),
              h >= ha, v >= va, 12'h000, (h == 0) && (v == 0)};
   endfunction
   task automatic cmp(input string tag, input logic [38:0] obs);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty obs=%h", tag, obs);
         return;
      end
      e = q.pop_front();
      checks++;
      assert (obs === e.v) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
      end
   endtask
   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask
   task automatic clr();
      k = 0; d_hs = 0; d_hb = 0; d_h0n = 0; d_h0a = -1; d_h0b = -1; d_fhb = -1; d_fhs = -1;
      s_fs1 = -1; s_fs2 = -1; s_fsn = 0; s_vs = 0; s_fhs = -1; s_fvs = -1;
      p_dhb = 1'b0; p_dhs = 1'b0; p_shs = 1'b0; p_svs = 1'b0;
   endtask
   task automatic step(input string tag);
      adv(rst_d, 1056, 628, dh, dv, dz);
      q.push_back('{tag: {tag, "_d"}, v: ev(dh, dv, dz, 800, 40, 128, 600, 1, 4)});
      adv(rst_s, 24, 12, sh, sv, sz);
      q.push_back('{tag: {tag, "_s"}, v: ev(sh, sv, sz, 16, 2, 3, 8, 1, 2)});
      @(posedge clk);
      #1;
      cmp({tag, "_d"}, od);
      cmp({tag, "_s"}, os);
      if (meas) begin
         k++;
         if (vd.hsync) d_hs++;
         if (vd.hblnk) d_hb++;
         if (vd.hcount == 11'd0) begin
            d_h0n++;
            if (d_h0a < 0) d_h0a = k;
            else if (d_h0b < 0) d_h0b = k;
         end
         if (vd.hblnk && !p_dhb && d_fhb < 0) d_fhb = int'(vd.hcount);
         if (vd.hsync && !p_dhs && d_fhs < 0) d_fhs = int'(vd.hcount);
         if (fs_s) begin
            s_fsn++;
            if (s_fs1 < 0) s_fs1 = k;
            else if (s_fs2 < 0) s_fs2 = k;
         end
         if (vs.vsync) s_vs++;
         if (vs.hsync && !p_shs && s_fhs < 0) s_fhs = int'(vs.hcount);
         if (vs.vsync && !p_svs && s_fvs < 0) s_fvs = int'(vs.vcount);
         p_dhb = vd.hblnk; p_dhs = vd.hsync; p_shs = vs.hsync; p_svs = vs.vsync;
      end
   endtask
   initial begin
      clr();
      step("init_rst");
      rst_d = 1'b0; rst_s = 1'b0;
      for (int i = 0; i < 1500; i++) step("free_run");
      rst_d = 1'b1; rst_s = 1'b1;
      for (int i = 0; i < 3; i++) step("rst_hold");
      rst_d = 1'b0; rst_s = 1'b0;
      meas = 1'b1;
      step("first");
      check("first_hcount_d", int'(vd.hcount), 1);
      check("first_hcount_s", int'(vs.hcount), 1);
      for (int i = 1; i < 3168; i++) step("sweep");
      check("hsync_cycles_3lines", d_hs, 384);
      check("hblnk_cycles_3lines", d_hb, 768);
      check("line_wraps", d_h0n, 3);
      check("first_wrap_cycle", d_h0a, 1056);
      check("line_period", d_h0b - d_h0a, 1056);
      check("hblnk_rise_hcount", d_fhb, 800);
      check("hsync_rise_hcount", d_fhs, 840);
      check("vcount_after_3lines", int'(vd.vcount), 3);
      check("s_first_frame_start", s_fs1, 288);
      check("s_frame_period", s_fs2 - s_fs1, 288);
      check("s_frame_starts", s_fsn, 11);
      check("s_vsync_cycles", s_vs, 528);
      check("s_hsync_rise_hcount", s_fhs, 18);
      check("s_vsync_rise_vcount", s_fvs, 9);
      meas = 1'b0;
      for (int i = 0; i < 400 && !(sh == 13 && sv == 6); i++) step("seek");
      check("seek_reached", (sh == 13 && sv == 6) ? 1 : 0, 1);
      rst_s = 1'b1;
      step("mid_rst");
      check("mid_rst_hcount", int'(vs.hcount), 0);
      rst_s = 1'b0;
      clr();
      meas = 1'b1;
      step("resume");
      check("resume_hcount", int'(vs.hcount), 1);
      for (int i = 1; i < 287; i++) step("resume_run");
      check("no_early_frame_start", s_fsn, 0);
      step("resume_wrap");
      check("frame_start_after_period", s_fsn, 1);
      check("frame_start_cycle", s_fs1, 288);
      check("scoreboard_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
